// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and helpers for the seven-segment scan controller.
package display_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [2:0] digit_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_e;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_BLANK = BLANK;
    localparam logic [1:0] ST_DRIVE = DRIVE;

    function automatic int digit_cyc(
        input int clk_hz,
        input int refresh_hz,
        input int n
    );
        return clk_hz / (refresh_hz * n);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Scan-controller bundle; define DISPLAY_SCAN_BRIGHTNESS_EN to add brightness.
interface display_scan_ctrl_if;

    logic                                 en;
    logic [display_pkg::NUM_DIGITS-1:0]   digit_mask;
    logic [display_pkg::NUM_DIGITS-1:0]   dp_in;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    logic [3:0]                           brightness;
`endif
    display_pkg::digit_sel_t              sel;
    logic [display_pkg::NUM_DIGITS-1:0]   an_n;
    logic                                 dp_n;
    logic                                 scan_tick;

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    modport master (
        output en, digit_mask, dp_in, brightness,
        input  sel, an_n, dp_n, scan_tick
    );
    modport slave (
        input  en, digit_mask, dp_in, brightness,
        output sel, an_n, dp_n, scan_tick
    );
`else
    modport master (
        output en, digit_mask, dp_in,
        input  sel, an_n, dp_n, scan_tick
    );
    modport slave (
        input  en, digit_mask, dp_in,
        output sel, an_n, dp_n, scan_tick
    );
`endif

endinterface

// File: rtl/display_scan_ctrl_clk_div_tick.sv
// Per-digit slot counter: flags the last blank cycle and the last slot cycle.
module clk_div_tick
    import display_pkg::*;
#(
    parameter int DIV   = 10,
    parameter int BLANK = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic end_blank_o,
    output logic end_slot_o
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] SLOT_LAST  = W'(DIV - 1);
    localparam logic [W-1:0] BLANK_LAST = W'(BLANK - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign end_blank_o = (cnt_q == BLANK_LAST);
    assign end_slot_o  = (cnt_q == SLOT_LAST);

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr_i || end_slot_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// 8-digit seven-segment scan controller with per-slot blanking.
// Optional PWM dimming under DISPLAY_SCAN_BRIGHTNESS_EN.
module display_scan_ctrl #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int REFRESH_HZ   = 1000,
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    display_scan_ctrl_if.slave bus
);

    import display_pkg::*;

    localparam int DIGIT_CYC = digit_cyc(CLK_HZ, REFRESH_HZ, NUM_DIGITS);
    localparam digit_sel_t LAST_SEL = digit_sel_t'(NUM_DIGITS - 1);

    if (DIGIT_CYC < BLANK_CYCLES + 2 || BLANK_CYCLES < 1) begin : g_bad_cfg
        $error("display_scan_ctrl: digit slot too short for blanking");
    end

    logic [1:0] state_q, state_d;
    digit_sel_t sel_q, sel_d;
    logic [7:0] an_q, an_d;
    logic       dp_q, dp_d;
    logic       tick_q, tick_d;
    logic       on_d;
    logic       lit;
    logic       end_blank;
    logic       end_slot;
    logic       cnt_clr;

    assign cnt_clr = !bus.en || (state_q == ST_IDLE);

    clk_div_tick #(
        .DIV   (DIGIT_CYC),
        .BLANK (BLANK_CYCLES)
    ) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (cnt_clr),
        .end_blank_o (end_blank),
        .end_slot_o  (end_slot)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        tick_d  = 1'b0;
        if (!bus.en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    sel_d   = '0;
                end
                ST_BLANK: begin
                    if (end_blank) state_d = ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (end_slot) begin
                        state_d = ST_BLANK;
                        sel_d   = (sel_q == LAST_SEL) ? '0 : sel_q + 3'd1;
                        tick_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
    logic [3:0] pwm_q, pwm_d;
    logic [3:0] bright_q, bright_d;

    // pwm_d is the phase of the cycle the registered outputs will show
    always_comb begin
        pwm_d    = 4'd0;
        bright_d = bright_q;
        if (state_d == ST_DRIVE && state_q == ST_DRIVE) begin
            pwm_d = pwm_q + 4'd1;
        end
        if (state_d == ST_BLANK && state_q != ST_BLANK) begin
            bright_d = bus.brightness;
        end
        on_d = (state_d == ST_DRIVE) && (pwm_d <= bright_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q    <= 4'd0;
            bright_q <= 4'd0;
        end else begin
            pwm_q    <= pwm_d;
            bright_q <= bright_d;
        end
    end
`else
    always_comb begin
        on_d = (state_d == ST_DRIVE);
    end
`endif

    // A masked digit keeps its slot timing but never asserts its anode
    always_comb begin
        lit        = on_d && bus.digit_mask[sel_d];
        an_d       = 8'hFF;
        an_d[sel_d] = ~lit;
        dp_d       = ~(lit && bus.dp_in[sel_d]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            an_q    <= 8'hFF;
            dp_q    <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.an_n      = an_q;
    assign bus.dp_n      = dp_q;
    assign bus.scan_tick = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a 10-cycle slot, 2-cycle blank.
module tb_display_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k_now = 0;

    always #5 clk = ~clk;

    display_scan_ctrl_if bus ();

    display_scan_ctrl #(
        .CLK_HZ       (8000),
        .REFRESH_HZ   (100),
        .NUM_DIGITS   (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] mask;
        logic [7:0] dp;
        int         k;
        logic [2:0] sel;
        logic [7:0] an;
        logic       dpn;
        logic       tick;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s k=%0d: got %h want %h", name, k_now, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k_now++;
    endtask

    task automatic restart(input logic [7:0] m, input logic [7:0] d);
        bus.en = 1'b0;
        step();
        bus.digit_mask = m;
        bus.dp_in      = d;
        bus.en         = 1'b1;
        step();
        k_now = 0;
    endtask

    // Reference: slot = k/10, first 2 cycles of a slot blank, pwm = pos-2
    task automatic check_all(input logic [7:0] m, input logic [7:0] d,
                             input int b);
        int s;
        int p;
        logic [7:0] an;
        logic dpn;
        s   = (k_now / 10) % 8;
        p   = k_now % 10;
        an  = 8'hFF;
        dpn = 1'b1;
        if (p >= 2 && m[s] && (p - 2) <= b) begin
            an[s] = 1'b0;
            dpn   = ~d[s];
        end
        chk("sel", 32'(bus.sel), 32'(s));
        chk("an_n", 32'(bus.an_n), 32'(an));
        chk("dp_n", 32'(bus.dp_n), 32'(dpn));
        chk("tick", 32'(bus.scan_tick), 32'(p == 0 && k_now > 0));
        chk("one_low", 32'($countones(~bus.an_n) <= 1), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{8'hFF, 8'h05, 0,  3'd0, 8'hFF, 1'b1, 1'b0};
        tbl[1]  = '{8'hFF, 8'h05, 1,  3'd0, 8'hFF, 1'b1, 1'b0};
        tbl[2]  = '{8'hFF, 8'h05, 2,  3'd0, 8'hFE, 1'b0, 1'b0};
        tbl[3]  = '{8'hFF, 8'h05, 9,  3'd0, 8'hFE, 1'b0, 1'b0};
        tbl[4]  = '{8'hFF, 8'h05, 10, 3'd1, 8'hFF, 1'b1, 1'b1};
        tbl[5]  = '{8'hFF, 8'h05, 12, 3'd1, 8'hFD, 1'b1, 1'b0};
        tbl[6]  = '{8'hFF, 8'h05, 22, 3'd2, 8'hFB, 1'b0, 1'b0};
        tbl[7]  = '{8'hFF, 8'h05, 75, 3'd7, 8'h7F, 1'b1, 1'b0};
        tbl[8]  = '{8'hFF, 8'h05, 80, 3'd0, 8'hFF, 1'b1, 1'b1};
        tbl[9]  = '{8'hFF, 8'h05, 82, 3'd0, 8'hFE, 1'b0, 1'b0};
        tbl[10] = '{8'h0F, 8'h00, 32, 3'd3, 8'hF7, 1'b1, 1'b0};
        tbl[11] = '{8'h0F, 8'h00, 40, 3'd4, 8'hFF, 1'b1, 1'b1};
        tbl[12] = '{8'h0F, 8'h00, 45, 3'd4, 8'hFF, 1'b1, 1'b0};
        tbl[13] = '{8'h0F, 8'h00, 79, 3'd7, 8'hFF, 1'b1, 1'b0};
        tbl[14] = '{8'h0F, 8'h00, 80, 3'd0, 8'hFF, 1'b1, 1'b1};

        rst_n          = 1'b0;
        bus.en         = 1'b0;
        bus.digit_mask = 8'h00;
        bus.dp_in      = 8'h00;
`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
        bus.brightness = 4'd15;
`endif
        #12;
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_an", 32'(bus.an_n), 32'hFF);
        chk("rst_dp", 32'(bus.dp_n), 32'd1);
        chk("rst_tick", 32'(bus.scan_tick), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (i == 0 || tbl[i].mask != tbl[i-1].mask ||
                tbl[i].dp != tbl[i-1].dp) begin
                restart(tbl[i].mask, tbl[i].dp);
            end
            while (k_now < tbl[i].k) step();
            chk("tbl_sel", 32'(bus.sel), 32'(tbl[i].sel));
            chk("tbl_an", 32'(bus.an_n), 32'(tbl[i].an));
            chk("tbl_dp", 32'(bus.dp_n), 32'(tbl[i].dpn));
            chk("tbl_tick", 32'(bus.scan_tick), 32'(tbl[i].tick));
        end

        restart(8'hFF, 8'h00);
        for (int j = 0; j < 86; j++) begin
            check_all(8'hFF, 8'h00, 15);
            step();
        end

        restart(8'h0F, 8'hA5);
        for (int j = 0; j < 90; j++) begin
            check_all(8'h0F, 8'hA5, 15);
            step();
        end

        // Enable drop in the third DRIVE cycle of digit 3
        restart(8'hFF, 8'h00);
        while (k_now < 34) step();
        chk("en_pre_an", 32'(bus.an_n), 32'hF7);
        bus.en = 1'b0;
        step();
        chk("en_off_an", 32'(bus.an_n), 32'hFF);
        chk("en_off_sel", 32'(bus.sel), 32'd3);
        chk("en_off_dp", 32'(bus.dp_n), 32'd1);
        chk("en_off_tick", 32'(bus.scan_tick), 32'd0);
        step();
        chk("en_idle_sel", 32'(bus.sel), 32'd3);
        chk("en_idle_an", 32'(bus.an_n), 32'hFF);
        bus.en = 1'b1;
        step();
        k_now = 0;
        for (int j = 0; j < 4; j++) begin
            check_all(8'hFF, 8'h00, 15);
            step();
        end

        // Asynchronous reset between edges during digit 5's DRIVE
        restart(8'hFF, 8'hFF);
        while (k_now < 53) step();
        chk("arst_pre_an", 32'(bus.an_n), 32'hDF);
        chk("arst_pre_dp", 32'(bus.dp_n), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_an", 32'(bus.an_n), 32'hFF);
        chk("arst_sel", 32'(bus.sel), 32'd0);
        chk("arst_dp", 32'(bus.dp_n), 32'd1);
        @(posedge clk);
        #1;
        chk("arst_hold_an", 32'(bus.an_n), 32'hFF);
        rst_n = 1'b1;
        step();
        k_now = 0;
        for (int j = 0; j < 13; j++) begin
            check_all(8'hFF, 8'hFF, 15);
            step();
        end

`ifdef DISPLAY_SCAN_BRIGHTNESS_EN
        bus.brightness = 4'd3;
        restart(8'hFF, 8'h00);
        for (int j = 0; j < 30; j++) begin
            check_all(8'hFF, 8'h00, (k_now < 10) ? 3 : 15);
            if (k_now == 5) bus.brightness = 4'd15;
            step();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
